reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 15 +
 rtl/reset_seq_counter.sv | 24 ++
 rtl/reset_sequencer.sv | 93 +++++++++
 tb/tb_reset_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package reset_seq_pkg;

  localparam int unsigned DefaultCntW   = 8;
  localparam int unsigned DefaultPorLen = 16;
  localparam int unsigned DefaultGap    = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StGap    = 2'd2,
    StDone   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reset_seq_counter.sv
// Loadable down-counter with zero flag; load wins over enable.
module reset_seq_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (load) begin
      count_q <= load_val;
    end else if (enable) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Generates a sync/async reset pair: async released first, sync held GAP cycles longer.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned POR_LEN = DefaultPorLen,
  parameter int unsigned GAP     = DefaultGap
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_sync_reset,
  output logic             o_async_reset,
  output logic             o_async_reset_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_start_ignored
);

  localparam logic [CNT_W-1:0] PorLoad = CNT_W'(POR_LEN - 1);
  localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP - 1);

  seq_state_e       state_q, state_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             ignored_d;

  reset_seq_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk     (clk),
    .load    (cnt_load),
    .enable  (cnt_en),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    ignored_d = 1'b0;
    if (sync_reset) begin
      state_d  = StAssert;
      cnt_load = 1'b1;
      cnt_val  = PorLoad;
    end else begin
      ignored_d = i_start && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d  = StAssert;
            cnt_load = 1'b1;
            // A zero length is promoted to one cycle.
            cnt_val  = (i_len == '0) ? '0 : i_len - CNT_W'(1);
          end
        end
        StAssert: begin
          if (cnt_zero) begin
            state_d  = StGap;
            cnt_load = 1'b1;
            cnt_val  = GapLoad;
          end else begin
            cnt_en = 1'b1;
          end
        end
        StGap: begin
          if (cnt_zero) begin
            state_d = StDone;
          end else begin
            cnt_en = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they align with state_q.
  always_ff @(posedge clk) begin
    state_q         <= state_d;
    o_sync_reset    <= (state_d == StAssert) || (state_d == StGap);
    o_async_reset   <= (state_d == StAssert);
    o_async_reset_n <= (state_d != StAssert);
    o_busy          <= (state_d != StIdle);
    o_done          <= (state_d == StDone);
    o_start_ignored <= ignored_d;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized self-checking bench with a position-based reference model of the reset sequence.
module tb_reset_sequencer;

  localparam int unsigned PorLen = 16;
  localparam int unsigned GapLen = 2;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_len = '0;
  logic       o_sync_reset, o_async_reset, o_async_reset_n, o_busy, o_done, o_start_ignored;

  reset_sequencer #(
    .CNT_W  (8),
    .POR_LEN(PorLen),
    .GAP    (GapLen)
  ) dut (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .i_start        (i_start),
    .i_len          (i_len),
    .o_sync_reset   (o_sync_reset),
    .o_async_reset  (o_async_reset),
    .o_async_reset_n(o_async_reset_n),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_start_ignored(o_start_ignored)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a sequence is L assert cycles, GapLen gap cycles and one done cycle, indexed by m_pos.
  bit m_in_seq = 1'b0;
  int m_pos    = 0;
  int m_len    = 0;
  bit m_ign    = 1'b0;
  bit chk_en   = 1'b0;

  int n_obs, n_async, n_async_n_low, n_sync, n_done, n_ign, n_idle, done_at;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual 'h%0h required 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_obs = 0; n_async = 0; n_async_n_low = 0; n_sync = 0;
    n_done = 0; n_ign = 0; n_idle = 0; done_at = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input int l);
    if (r) begin
      m_in_seq = 1'b1; m_pos = 0; m_len = PorLen; m_ign = 1'b0; chk_en = 1'b1;
    end else if (!m_in_seq) begin
      m_ign = 1'b0;
      if (s) begin
        m_in_seq = 1'b1; m_pos = 0; m_len = (l == 0) ? 1 : l;
      end
    end else begin
      m_ign = s;
      m_pos++;
      if (m_pos == m_len + int'(GapLen) + 1) m_in_seq = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input logic [7:0] l);
    #1;
    sync_reset = r; i_start = s; i_len = l;
    @(posedge clk);
    model_step(r, s, int'(l));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_async, e_sync, e_done;
      logic [5:0] exp_v, act_v;
      e_async = m_in_seq && (m_pos < m_len);
      e_sync  = m_in_seq && (m_pos < m_len + int'(GapLen));
      e_done  = m_in_seq && (m_pos == m_len + int'(GapLen));
      exp_v = {e_sync, e_async, ~e_async, m_in_seq, e_done, m_ign};
      act_v = {o_sync_reset, o_async_reset, o_async_reset_n, o_busy, o_done, o_start_ignored};
      chk("outputs{sync,async,async_n,busy,done,ign}", int'(act_v), int'(exp_v));
      n_obs++;
      if (o_async_reset) n_async++;
      if (!o_async_reset_n) n_async_n_low++;
      if (o_sync_reset) n_sync++;
      if (o_start_ignored) n_ign++;
      if (!o_busy) n_idle++;
      if (o_done) begin
        n_done++;
        if (done_at == 0) done_at = n_obs;
      end
    end
  end

  initial begin
    clear_counts();
    // Power-on: three reset cycles, then free-running.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'd0);
    clear_counts();
    idle(25);
    chk("por_async_cycles", n_async, 16);
    chk("por_sync_cycles", n_sync, 18);
    chk("por_done_at", done_at, 19);
    chk("por_done_count", n_done, 1);

    // Start with length 5.
    clear_counts();
    cycle(1'b0, 1'b1, 8'd5);
    idle(12);
    chk("len5_async_n_low", n_async_n_low, 5);
    chk("len5_sync_cycles", n_sync, 7);
    chk("len5_done_count", n_done, 1);

    // Zero length behaves as one.
    clear_counts();
    cycle(1'b0, 1'b1, 8'd0);
    idle(8);
    chk("len0_async_cycles", n_async, 1);
    chk("len0_sync_cycles", n_sync, 3);

    // Start during assert is ignored and does not alter the length.
    clear_counts();
    cycle(1'b0, 1'b1, 8'd8);
    idle(3);
    cycle(1'b0, 1'b1, 8'd3);
    idle(15);
    chk("ignore_pulses", n_ign, 1);
    chk("ignore_async_cycles", n_async, 8);
    chk("ignore_done_count", n_done, 1);

    // Reset pulse in gap restarts the full power-on sequence.
    cycle(1'b0, 1'b1, 8'd4);
    idle(4);
    cycle(1'b1, 1'b0, 8'd0);
    clear_counts();
    idle(25);
    chk("gap_rst_async_cycles", n_async, 16);
    chk("gap_rst_sync_cycles", n_sync, 18);
    chk("gap_rst_done_at", done_at, 19);

    // Start held high with length 2: period of 6 with a single idle cycle.
    clear_counts();
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'd2);
    chk("held_done_count", n_done, 5);
    chk("held_idle_count", n_idle, 5);
    chk("held_async_cycles", n_async, 10);
    idle(8);

    // Random traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 600; i++) begin
      bit r, s;
      logic [7:0] l;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      cycle(r, s, l);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
